// File: rtl/gen_sys_event_lvl_if.sv
// Control/status bundle of the gravity tick generator: level commands,
// soft-drop and pause requests in; tick pulse, level and period out.
interface gen_sys_event_lvl_if #(
  parameter int unsigned LEVEL_W = 5,
  parameter int unsigned CNT_W   = 32
);

  logic               level_inc_i;
  logic               level_load_i;
  logic [LEVEL_W-1:0] level_val_i;
  logic               fast_i;
  logic               pause_i;
  logic               sys_event_o;
  logic [LEVEL_W-1:0] level_o;
  logic [CNT_W-1:0]   period_o;

  // Game logic side: issues commands, consumes ticks and HUD values
  modport master (
    output level_inc_i,
    output level_load_i,
    output level_val_i,
    output fast_i,
    output pause_i,
    input  sys_event_o,
    input  level_o,
    input  period_o
  );

  // Tick generator side
  modport slave (
    input  level_inc_i,
    input  level_load_i,
    input  level_val_i,
    input  fast_i,
    input  pause_i,
    output sys_event_o,
    output level_o,
    output period_o
  );

endinterface

// File: rtl/gen_sys_event_lvl.sv
// Gravity tick generator: one-cycle sys_event_o every eff clocks, where eff
// shrinks linearly with the held level and can be shortened by soft-drop.
module gen_sys_event_lvl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned LEVEL_W     = 5,
  parameter int unsigned LEVEL_MAX   = 20,
  parameter int unsigned PERIOD_MAX  = 67_000_000,
  parameter int unsigned PERIOD_MIN  = 10_000_000,
  parameter int unsigned PERIOD_STEP = 4_000_000,
  parameter int unsigned FAST_PERIOD = 5_000_000
) (
  input  logic                 clk,
  input  logic                 srst,
  gen_sys_event_lvl_if.slave   bus
);

  // Product is sized so level*PERIOD_STEP can never wrap
  localparam int unsigned PROD_W = CNT_W + LEVEL_W;

  localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(LEVEL_MAX);
  localparam logic [CNT_W-1:0]   P_MAX     = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0]   P_MIN     = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0]   P_FAST    = CNT_W'(FAST_PERIOD);
  localparam logic [PROD_W-1:0]  P_MAX_W   = PROD_W'(PERIOD_MAX);
  localparam logic [PROD_W-1:0]  STEP_W    = PROD_W'(PERIOD_STEP);
  localparam logic [PROD_W-1:0]  DROP_MAX  = PROD_W'(PERIOD_MAX - PERIOD_MIN);

  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_nxt;
  logic [CNT_W-1:0]   period_q;
  logic [CNT_W-1:0]   period_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   eff_c;
  logic [PROD_W-1:0]  drop_c;
  logic               level_cmd_c;
  logic               hit_c;

  // Level command decode: load beats inc, both saturate at LEVEL_MAX
  always_comb begin
    level_cmd_c = bus.level_load_i | bus.level_inc_i;
    level_nxt   = level_q;
    if (bus.level_load_i) begin
      level_nxt = (bus.level_val_i > LVL_MAX) ? LVL_MAX : bus.level_val_i;
    end else if (bus.level_inc_i) begin
      level_nxt = (level_q >= LVL_MAX) ? LVL_MAX : level_q + LEVEL_W'(1);
    end
  end

  // Period derived from the next level so level and period move together
  always_comb begin
    drop_c     = PROD_W'(level_nxt) * STEP_W;
    period_nxt = P_MIN;
    if (drop_c <= DROP_MAX) begin
      period_nxt = CNT_W'(P_MAX_W - drop_c);
    end
  end

  // Effective period and terminal-count detect (>= so a shorter eff fires at once)
  always_comb begin
    eff_c = period_q;
    if (bus.fast_i && (P_FAST < period_q)) begin
      eff_c = P_FAST;
    end
    hit_c = (cnt_q >= (eff_c - CNT_W'(1)));
  end

  always_comb begin
    cnt_nxt = cnt_q + CNT_W'(1);
    if (level_cmd_c) begin
      cnt_nxt = '0;
    end else if (bus.pause_i) begin
      cnt_nxt = cnt_q;
    end else if (hit_c) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      level_q  <= '0;
      period_q <= P_MAX;
      cnt_q    <= '0;
    end else begin
      if (level_cmd_c) begin
        level_q  <= level_nxt;
        period_q <= period_nxt;
      end
      cnt_q <= cnt_nxt;
    end
  end

  assign bus.sys_event_o = !srst && !bus.pause_i && hit_c;
  assign bus.level_o     = level_q;
  assign bus.period_o    = period_q;

endmodule

// File: tb/tb_gen_sys_event_lvl.sv
// Self-checking bench for gen_sys_event_lvl: level/period table, directed
// tick-timing sequences, and randomized traffic against a reference model.
module tb_gen_sys_event_lvl;

  localparam int CNT_W = 8;
  localparam int LEVEL_W = 4;
  localparam int LMAX = 7;
  localparam int PMAX = 20;
  localparam int PMIN = 6;
  localparam int STEP = 4;
  localparam int FAST = 3;

  logic clk = 1'b0;
  logic srst;

  gen_sys_event_lvl_if #(.LEVEL_W(LEVEL_W), .CNT_W(CNT_W)) bus ();

  gen_sys_event_lvl #(
    .CNT_W(CNT_W), .LEVEL_W(LEVEL_W), .LEVEL_MAX(LMAX),
    .PERIOD_MAX(PMAX), .PERIOD_MIN(PMIN), .PERIOD_STEP(STEP), .FAST_PERIOD(FAST)
  ) dut (
    .clk (clk),
    .srst(srst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int m_level;
  int m_phase;
  logic last_ev;

  typedef struct {
    bit srst;
    bit inc;
    bit load;
    int val;
    int exp_level;
    int exp_period;
  } row_t;

  row_t rows [14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_period(input int l);
    int p;
    p = PMAX - l * STEP;
    return (p < PMIN) ? PMIN : p;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock: compare against the model mid-cycle, then advance the model
  task automatic cyc();
    int p;
    int e;
    bit ev_exp;
    @(negedge clk);
    p = m_period(m_level);
    e = bus.fast_i ? imin(p, FAST) : p;
    ev_exp = !srst && !bus.pause_i && (m_phase >= e - 1);
    chk("model_event", int'(bus.sys_event_o), int'(ev_exp));
    chk("model_level", int'(bus.level_o), m_level);
    chk("model_period", int'(bus.period_o), p);
    last_ev = bus.sys_event_o;
    if (srst) begin
      m_level = 0;
      m_phase = 0;
    end else begin
      if (bus.level_load_i) m_level = imin(int'(bus.level_val_i), LMAX);
      else if (bus.level_inc_i) m_level = imin(m_level + 1, LMAX);
      if (bus.level_load_i || bus.level_inc_i) m_phase = 0;
      else if (!bus.pause_i) m_phase = ev_exp ? 0 : m_phase + 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Count cycles up to and including the next pulse; bounded wait
  task automatic wait_ev(input string name, input int exp);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!last_ev && n < exp + 5);
    chk(name, last_ev ? n : -1, exp);
  endtask

  task automatic idle(input int n, output int evs);
    evs = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      evs += int'(last_ev);
    end
  endtask

  task automatic pulse_cmd(input bit inc, input bit load, input int val);
    bus.level_inc_i  = inc;
    bus.level_load_i = load;
    bus.level_val_i  = LEVEL_W'(val);
    cyc();
    bus.level_inc_i  = 1'b0;
    bus.level_load_i = 1'b0;
  endtask

  initial begin
    int evs;
    int exp_p [5];
    srst = 1'b1;
    bus.level_inc_i = 1'b0;
    bus.level_load_i = 1'b0;
    bus.level_val_i = '0;
    bus.fast_i = 1'b0;
    bus.pause_i = 1'b0;
    last_ev = 1'b0;

    rows[0]  = '{1, 0, 0, 0, 0, 20};
    rows[1]  = '{0, 1, 0, 0, 1, 16};
    rows[2]  = '{0, 1, 0, 0, 2, 12};
    rows[3]  = '{0, 1, 0, 0, 3, 8};
    rows[4]  = '{0, 1, 0, 0, 4, 6};
    rows[5]  = '{0, 0, 1, 9, 7, 6};
    rows[6]  = '{0, 1, 0, 0, 7, 6};
    rows[7]  = '{0, 1, 1, 2, 2, 12};
    rows[8]  = '{0, 0, 1, 0, 0, 20};
    rows[9]  = '{0, 0, 1, 15, 7, 6};
    rows[10] = '{1, 0, 1, 3, 0, 20};
    rows[11] = '{0, 0, 1, 3, 3, 8};
    rows[12] = '{0, 0, 0, 0, 3, 8};
    rows[13] = '{1, 0, 0, 0, 0, 20};

    @(posedge clk);
    #1;
    m_level = 0;
    m_phase = 0;

    // Level/period arithmetic table
    foreach (rows[i]) begin
      srst = rows[i].srst;
      bus.level_inc_i = rows[i].inc;
      bus.level_load_i = rows[i].load;
      bus.level_val_i = LEVEL_W'(rows[i].val);
      cyc();
      chk($sformatf("tbl%0d_level", i), int'(bus.level_o), rows[i].exp_level);
      chk($sformatf("tbl%0d_period", i), int'(bus.period_o), rows[i].exp_period);
    end
    srst = 1'b0;
    bus.level_inc_i = 1'b0;
    bus.level_load_i = 1'b0;

    // Free-running ticks at level 0
    chk("t1_level", int'(bus.level_o), 0);
    chk("t1_period", int'(bus.period_o), 20);
    wait_ev("t1_first", 20);
    wait_ev("t1_second", 20);
    wait_ev("t1_third", 20);

    // Level stepping restarts the count
    exp_p = '{16, 12, 8, 6, 6};
    for (int i = 0; i < 5; i++) begin
      pulse_cmd(1'b1, 1'b0, 0);
      chk($sformatf("t2_period%0d", i), int'(bus.period_o), exp_p[i]);
      wait_ev($sformatf("t2_ev%0d", i), exp_p[i]);
    end
    for (int i = 0; i < 4; i++) pulse_cmd(1'b1, 1'b0, 0);
    chk("t2_sat_level", int'(bus.level_o), 7);
    chk("t2_sat_period", int'(bus.period_o), 6);

    // Load clamp and load-over-inc priority
    pulse_cmd(1'b0, 1'b1, 9);
    chk("t3_load9_level", int'(bus.level_o), 7);
    chk("t3_load9_period", int'(bus.period_o), 6);
    pulse_cmd(1'b1, 1'b1, 2);
    chk("t3_prio_level", int'(bus.level_o), 2);
    chk("t3_prio_period", int'(bus.period_o), 12);

    // Soft-drop raised late in the count fires immediately
    pulse_cmd(1'b0, 1'b1, 0);
    idle(10, evs);
    chk("t4_pre_ev", evs, 0);
    bus.fast_i = 1'b1;
    cyc();
    chk("t4_fast_now", int'(last_ev), 1);
    wait_ev("t4_fast_a", 3);
    wait_ev("t4_fast_b", 3);
    bus.fast_i = 1'b0;
    wait_ev("t4_slow", 20);

    // Pause freezes the count; resume continues from it
    idle(15, evs);
    chk("t5_pre_ev", evs, 0);
    bus.pause_i = 1'b1;
    idle(100, evs);
    chk("t5_pause_ev", evs, 0);
    bus.pause_i = 1'b0;
    wait_ev("t5_resume", 5);
    bus.pause_i = 1'b1;
    bus.fast_i = 1'b1;
    idle(20, evs);
    chk("t5_pause_fast_ev", evs, 0);
    bus.pause_i = 1'b0;
    bus.fast_i = 1'b0;
    wait_ev("t5_resume2", 20);

    // Reset mid-count, with a competing load
    pulse_cmd(1'b0, 1'b1, 3);
    chk("t6_level3", int'(bus.level_o), 3);
    idle(4, evs);
    srst = 1'b1;
    cyc();
    chk("t6_rst_ev0", int'(last_ev), 0);
    bus.level_load_i = 1'b1;
    bus.level_val_i = LEVEL_W'(5);
    cyc();
    chk("t6_rst_ev1", int'(last_ev), 0);
    srst = 1'b0;
    bus.level_load_i = 1'b0;
    chk("t6_level", int'(bus.level_o), 0);
    chk("t6_period", int'(bus.period_o), 20);
    wait_ev("t6_first", 20);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      srst = ($urandom_range(0, 199) == 0);
      bus.level_inc_i = ($urandom_range(0, 39) == 0);
      bus.level_load_i = ($urandom_range(0, 59) == 0);
      bus.level_val_i = LEVEL_W'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) bus.fast_i = ~bus.fast_i;
      if ($urandom_range(0, 29) == 0) bus.pause_i = ~bus.pause_i;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
